pipelined_barrel_shifter: RTL and testbench

PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

---
 rtl/pipelined_barrel_shifter.sv | 181 ++++++++++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_barrel_shifter.sv
// Two-stage pipelined barrel shifter with valid/ready handshakes on both sides.
// Stage 1 applies the low half of the shift amount. Stage 2 applies the rest
// and holds the result for downstream. out_lost collects every discarded 1-bit
// along the way.
module pipelined_barrel_shifter #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_lost
);

  // Shift-amount bits [SPLIT-1:0] are resolved in stage 1, the rest in stage 2.
  localparam int SPLIT = SHW / 2;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;

  // Stage 1 registers: partially shifted data plus everything stage 2 needs.
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q,  s1_data_d;
  logic             s1_lost_q,  s1_lost_d;
  logic [1:0]       s1_mode_q,  s1_mode_d;
  logic [SHW-1:SPLIT] s1_shamt_q, s1_shamt_d;

  // Stage 2 registers: these drive the outputs directly.
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_data_q,  s2_data_d;
  logic             s2_zero_q,  s2_zero_d;
  logic             s2_lost_q,  s2_lost_d;

  logic s2_adv;
  logic in_fire;

  // Log-step cascade. Step gi shifts by 2**gi when its shift bit is set. The
  // chain restarts from the stage-1 registers at step SPLIT.
  logic [WIDTH-1:0] step_in       [SHW];
  logic [WIDTH-1:0] step_out      [SHW];
  logic             step_lost_in  [SHW];
  logic             step_lost_out [SHW];

  for (genvar gi = 0; gi < SHW; gi++) begin : g_step
    localparam int K = 1 << gi;

    logic [1:0]       mode;
    logic             en;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] shifted;
    logic             dropped;

    if (gi < SPLIT) begin : g_s1_ctl
      assign mode = in_mode;
      assign en   = in_shamt[gi];
    end else begin : g_s2_ctl
      assign mode = s1_mode_q;
      assign en   = s1_shamt_q[gi];
    end

    if (gi == 0) begin : g_first
      assign step_in[gi]      = in_data;
      assign step_lost_in[gi] = 1'b0;
    end else if (gi == SPLIT) begin : g_join
      assign step_in[gi]      = s1_data_q;
      assign step_lost_in[gi] = s1_lost_q;
    end else begin : g_chain
      assign step_in[gi]      = step_out[gi-1];
      assign step_lost_in[gi] = step_lost_out[gi-1];
    end

    assign x = step_in[gi];

    // Fixed-distance shift for this step and the bits it would push out.
    // After any earlier arithmetic step the MSB still equals the original
    // sign bit, so x[WIDTH-1] is a valid fill source in either stage.
    always_comb begin
      shifted = x;
      dropped = 1'b0;
      case (mode)
        MODE_SLL: begin
          shifted = x << K;
          dropped = |x[WIDTH-1 -: K];
        end
        MODE_SRL: begin
          shifted = x >> K;
          dropped = |x[K-1:0];
        end
        MODE_SRA: begin
          shifted = {{K{x[WIDTH-1]}}, x[WIDTH-1:K]};
          dropped = |x[K-1:0];
        end
        default: begin
          shifted = {x[K-1:0], x[WIDTH-1:K]};
          dropped = 1'b0;
        end
      endcase
    end

    assign step_out[gi]      = en ? shifted : x;
    assign step_lost_out[gi] = step_lost_in[gi] | (en & dropped);
  end

  // Handshake logic. Stage 2 moves whenever it is empty or its result leaves.
  // in_ready is gated by rst so nothing is accepted during reset.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign in_ready = !rst && (!s1_valid_q || s2_adv);
  assign in_fire  = in_valid && in_ready;

  // Next-state for both stages. Registers hold their value unless the stage moves.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_lost_d  = s1_lost_q;
    s1_mode_d  = s1_mode_q;
    s1_shamt_d = s1_shamt_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_zero_d  = s2_zero_q;
    s2_lost_d  = s2_lost_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_data_d  = step_out[SPLIT-1];
      s1_lost_d  = step_lost_out[SPLIT-1];
      s1_mode_d  = in_mode;
      s1_shamt_d = in_shamt[SHW-1:SPLIT];
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = step_out[SHW-1];
        s2_zero_d = (step_out[SHW-1] == '0);
        s2_lost_d = step_lost_out[SHW-1];
      end
    end
  end

  // Pipeline registers. The asynchronous reset empties both stages and clears the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_lost_q  <= 1'b0;
      s1_mode_q  <= 2'b00;
      s1_shamt_q <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_zero_q  <= 1'b0;
      s2_lost_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_lost_q  <= s1_lost_d;
      s1_mode_q  <= s1_mode_d;
      s1_shamt_q <= s1_shamt_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_zero_q  <= s2_zero_d;
      s2_lost_q  <= s2_lost_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_zero  = s2_zero_q;
  assign out_lost  = s2_lost_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter. It has a WIDTH=8 lane that
// runs the directed cases and then a random stream. Two more lanes, WIDTH=4
// and WIDTH=32, run random streams. Expected results come from an
// arithmetic reference model.
module tb_pipelined_barrel_shifter;

  typedef struct packed {
    logic [31:0] data;
    logic        lost;
    logic        zero;
  } exp_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: shift as integer arithmetic on a wide value, then mask to w bits.
  function automatic exp_t ref_model(input logic [63:0] d_in, input int w, input int sh, input int m);
    logic [63:0] mask, d, full, res;
    logic        lost;
    exp_t        r;
    mask = (64'd1 << w) - 64'd1;
    d    = d_in & mask;
    res  = '0;
    lost = 1'b0;
    case (m)
      0: begin
        full = d << sh;
        res  = full & mask;
        lost = (full >> w) != 0;
      end
      1: begin
        res  = d >> sh;
        lost = (d & ((64'd1 << sh) - 64'd1)) != 0;
      end
      2: begin
        res = d >> sh;
        if (((d >> (w - 1)) & 64'd1) != 0) res = res | (mask & ~(mask >> sh));
        lost = (d & ((64'd1 << sh) - 64'd1)) != 0;
      end
      default: begin
        res  = (sh == 0) ? d : (((d >> sh) | (d << (w - sh))) & mask);
        lost = 1'b0;
      end
    endcase
    r.data = res[31:0];
    r.lost = lost;
    r.zero = (res == 0);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- WIDTH=8 lane ----------------
  logic       rst8, in_valid8, in_ready8, out_valid8, out_ready8, out_zero8, out_lost8;
  logic [7:0] in_data8, out_data8;
  logic [2:0] in_shamt8;
  logic [1:0] in_mode8;
  exp_t       q8[$];
  int         n_out8 = 0;
  logic       done8 = 1'b0;

  pipelined_barrel_shifter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .in_shamt(in_shamt8), .in_mode(in_mode8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .out_zero(out_zero8), .out_lost(out_lost8)
  );

  // Monitor: each completed output transfer is checked against the oldest expectation.
  always @(negedge clk) begin
    if (!rst8 && out_valid8 && out_ready8) begin
      $display("w8  out data=%0h lost=%0b zero=%0b", out_data8, out_lost8, out_zero8);
      if (q8.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out8_unexpected: got data 0x%0h, expected no output", out_data8);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("out8", 64'({out_data8, out_lost8, out_zero8}), 64'({e.data[7:0], e.lost, e.zero}));
      end
      n_out8++;
    end
  end

  task automatic push8(input logic [7:0] d, input logic [2:0] sh, input logic [1:0] m);
    q8.push_back(ref_model(64'(d), 8, int'(sh), int'(m)));
  endtask

  task automatic drive8(input logic [7:0] d, input logic [2:0] sh, input logic [1:0] m);
    in_valid8 = 1'b1;
    in_data8  = d;
    in_shamt8 = sh;
    in_mode8  = m;
  endtask

  // Single transfer into an empty pipeline. Checks the latency of 2 and the literal result.
  // The caller enters just after a rising edge with out_ready8=1.
  task automatic run_directed(input string name, input logic [7:0] d, input logic [2:0] sh,
                              input logic [1:0] m, input logic [7:0] xd, input logic xl, input logic xz);
    drive8(d, sh, m);
    @(negedge clk);
    check({name, "_in_ready"}, 64'(in_ready8), 64'd1);
    push8(d, sh, m);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    in_data8  = 8'($urandom);
    in_shamt8 = 3'($urandom);
    in_mode8  = 2'($urandom);
    @(negedge clk);
    check({name, "_lat_e1"}, 64'(out_valid8), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({name, "_lat_e2"}, 64'(out_valid8), 64'd1);
    check({name, "_result"}, 64'({out_data8, out_lost8, out_zero8}), 64'({xd, xl, xz}));
    @(posedge clk); #1;
  endtask

  task automatic drain8(input string name);
    out_ready8 = 1'b1;
    for (int t = 0; t < 40 && q8.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    check(name, 64'(q8.size()), 64'd0);
  endtask

  logic [7:0] st_d  [3] = '{8'hF0, 8'h0F, 8'h80};
  logic [2:0] st_sh [3] = '{3'd2, 3'd1, 3'd3};
  logic [1:0] st_m  [3] = '{2'b11, 2'b00, 2'b10};

  // WIDTH=8 stimulus: reset, directed cases, stall, mid-flight reset, then random traffic.
  initial begin
    exp_t held;
    int   snap;
    logic accepted;
    rst8 = 1'b1; in_valid8 = 1'b0; out_ready8 = 1'b0;
    in_data8 = '0; in_shamt8 = '0; in_mode8 = '0;
    #2;
    check("reset_out_valid", 64'(out_valid8), 64'd0);
    check("reset_out_data", 64'({out_data8, out_lost8, out_zero8}), 64'd0);
    check("reset_in_ready", 64'(in_ready8), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst8 = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", 64'(in_ready8), 64'd1);
    @(posedge clk); #1;
    out_ready8 = 1'b1;

    run_directed("sll_b4_3",  8'hB4, 3'd3, 2'b00, 8'hA0, 1'b1, 1'b0);
    run_directed("sra_96_2",  8'h96, 3'd2, 2'b10, 8'hE5, 1'b1, 1'b0);
    run_directed("srl_96_2",  8'h96, 3'd2, 2'b01, 8'h25, 1'b1, 1'b0);
    run_directed("ror_81_1",  8'h81, 3'd1, 2'b11, 8'hC0, 1'b0, 1'b0);
    run_directed("srl_00_0",  8'h00, 3'd0, 2'b01, 8'h00, 1'b0, 1'b1);
    run_directed("sll_c3_0",  8'hC3, 3'd0, 2'b00, 8'hC3, 1'b0, 1'b0);
    run_directed("sra_80_7",  8'h80, 3'd7, 2'b10, 8'hFF, 1'b0, 1'b0);

    // Stall: three back-to-back offers while downstream blocks.
    snap = n_out8;
    out_ready8 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive8(st_d[k], st_sh[k], st_m[k]);
      @(negedge clk);
      if (k < 2) begin
        check($sformatf("stall_accept%0d", k), 64'(in_ready8), 64'd1);
        push8(st_d[k], st_sh[k], st_m[k]);
      end else begin
        check("stall_blocked", 64'(in_ready8), 64'd0);
      end
      @(posedge clk); #1;
    end
    held = ref_model(64'(st_d[0]), 8, int'(st_sh[0]), int'(st_m[0]));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("stall_hold", 64'({out_valid8, out_data8, out_lost8, out_zero8}),
            64'({1'b1, held.data[7:0], held.lost, held.zero}));
      check("stall_in_ready", 64'(in_ready8), 64'd0);
      @(posedge clk); #1;
    end
    out_ready8 = 1'b1;
    accepted = 1'b0;
    for (int t = 0; t < 10 && !accepted; t++) begin
      @(negedge clk);
      if (in_ready8) begin
        push8(st_d[2], st_sh[2], st_m[2]);
        accepted = 1'b1;
      end
      @(posedge clk); #1;
    end
    check("stall_third_accepted", 64'(accepted), 64'd1);
    in_valid8 = 1'b0;
    drain8("stall_drain");
    check("stall_count", 64'(n_out8 - snap), 64'd3);

    // Asynchronous reset between edges with two transfers in flight.
    out_ready8 = 1'b0;
    drive8(8'h3C, 3'd1, 2'b01);
    @(negedge clk); push8(8'h3C, 3'd1, 2'b01);
    @(posedge clk); #1;
    drive8(8'hC3, 3'd2, 2'b00);
    @(negedge clk); push8(8'hC3, 3'd2, 2'b00);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(negedge clk);
    check("rst_mid_pre_valid", 64'(out_valid8), 64'd1);
    @(posedge clk); #3;
    rst8 = 1'b1;
    #1;
    check("rst_mid_out_valid", 64'(out_valid8), 64'd0);
    check("rst_mid_out_regs", 64'({out_data8, out_lost8, out_zero8}), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready8), 64'd0);
    rst8 = 1'b0;
    q8.delete();
    snap = n_out8;
    @(negedge clk);
    check("rst_mid_ready_after", 64'(in_ready8), 64'd1);
    out_ready8 = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_mid_no_stale", 64'(n_out8 - snap), 64'd0);
    run_directed("post_rst", 8'hB4, 3'd3, 2'b00, 8'hA0, 1'b1, 1'b0);

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      in_valid8  = ($urandom_range(0, 3) != 0);
      in_data8   = 8'($urandom);
      in_shamt8  = 3'($urandom);
      in_mode8   = 2'($urandom);
      out_ready8 = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (in_valid8 && in_ready8) push8(in_data8, in_shamt8, in_mode8);
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    drain8("rand8_drain");
    done8 = 1'b1;
  end

  // ---------------- WIDTH=4 and WIDTH=32 lanes (random only) ----------------
  for (genvar gi = 0; gi < 2; gi++) begin : lane
    localparam int W  = (gi == 0) ? 4 : 32;
    localparam int SW = $clog2(W);

    logic          rst, in_valid, in_ready, out_valid, out_ready, out_zero, out_lost;
    logic [W-1:0]  in_data, out_data;
    logic [SW-1:0] in_shamt;
    logic [1:0]    in_mode;
    logic          done = 1'b0;
    exp_t          q[$];

    pipelined_barrel_shifter #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_shamt(in_shamt), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_zero(out_zero), .out_lost(out_lost)
    );

    // Random stimulus for this lane: reset, then a random stream with random backpressure.
    initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_data = '0; in_shamt = '0; in_mode = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check($sformatf("w%0d_reset_state", W), 64'({in_ready, out_valid}), 64'b10);
      @(posedge clk); #1;
      for (int c = 0; c < 400; c++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_data   = W'($urandom);
        in_shamt  = SW'($urandom);
        in_mode   = 2'($urandom);
        out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (in_valid && in_ready)
          q.push_back(ref_model(64'(in_data), W, int'(in_shamt), int'(in_mode)));
        @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int t = 0; t < 40 && q.size() != 0; t++) begin
        @(posedge clk); #1;
      end
      check($sformatf("w%0d_drain", W), 64'(q.size()), 64'd0);
      done = 1'b1;
    end

    // Monitor for this lane.
    always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
        $display("w%0d out data=%0h lost=%0b zero=%0b", W, out_data, out_lost, out_zero);
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL w%0d_unexpected: got data 0x%0h, expected no output", W, out_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          check($sformatf("out_w%0d", W), 64'({out_data, out_lost, out_zero}),
                64'({e.data[W-1:0], e.lost, e.zero}));
        end
      end
    end
  end

  // Summary once every lane is done.
  initial begin
    wait (done8 && lane[0].done && lane[1].done);
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected all lanes done");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
